// File: rtl/regread_stage.sv
// Register-read stage: fair IQ/LSQ arbitration, operand read from the physical
// register file, registered hand-off to execute. Define REGREAD_WB_BYPASS_EN for write-back forwarding.
module regread_stage #(
    parameter int DATA_W = 32,
    parameter int PREG_W = 6,
    parameter int ROB_W  = 6,
    parameter int PAY_W  = 64,
    parameter int NUM_WB = 2
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     FREEZE,

    input  logic                     iq_valid,
    input  logic [ROB_W-1:0]         iq_rob,
    input  logic [PREG_W-1:0]        iq_srcA,
    input  logic [PREG_W-1:0]        iq_srcB,
    input  logic [PREG_W-1:0]        iq_dest,
    input  logic [PAY_W-1:0]         iq_payload,
    output logic                     iq_pop,

    input  logic                     lsq_valid,
    input  logic [ROB_W-1:0]         lsq_rob,
    input  logic [PREG_W-1:0]        lsq_srcA,
    input  logic [PREG_W-1:0]        lsq_srcB,
    input  logic [PREG_W-1:0]        lsq_dest,
    input  logic [PAY_W-1:0]         lsq_payload,
    output logic                     lsq_pop,

    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_is_mem,
    output logic [ROB_W-1:0]         out_rob,
    output logic [DATA_W-1:0]        out_opA,
    output logic [DATA_W-1:0]        out_opB,
    output logic [PREG_W-1:0]        out_dest,
    output logic [PAY_W-1:0]         out_payload,

    input  logic [NUM_WB-1:0]        wb_en,
    input  logic [NUM_WB*PREG_W-1:0] wb_idx,
    input  logic [NUM_WB*DATA_W-1:0] wb_data
);

    localparam int NREG = 1 << PREG_W;

    // Handshake: an output beat transfers on a cycle with out_valid && out_ready;
    // the register may reload whenever it is empty or being drained, unless FREEZE.

    logic [DATA_W-1:0] rf_q [NREG];

    logic              last_grant_q, last_grant_d;
    logic              out_valid_q, out_valid_d;
    logic              out_is_mem_q, out_is_mem_d;
    logic [ROB_W-1:0]  out_rob_q, out_rob_d;
    logic [DATA_W-1:0] out_opA_q, out_opA_d;
    logic [DATA_W-1:0] out_opB_q, out_opB_d;
    logic [PREG_W-1:0] out_dest_q, out_dest_d;
    logic [PAY_W-1:0]  out_payload_q, out_payload_d;

    logic              advance;
    logic              grant_lsq;
    logic              any_valid;
    logic [PREG_W-1:0] sel_srcA, sel_srcB;
    logic [DATA_W-1:0] rd_opA, rd_opB;

    // Arbitration: a lone valid queue wins; on a tie the queue not granted last wins.
    assign advance   = !FREEZE && (!out_valid_q || out_ready);
    assign any_valid = iq_valid || lsq_valid;
    assign grant_lsq = lsq_valid && (!iq_valid || !last_grant_q);

    assign iq_pop  = RESET && advance && iq_valid && !grant_lsq;
    assign lsq_pop = RESET && advance && grant_lsq;

    assign sel_srcA = grant_lsq ? lsq_srcA : iq_srcA;
    assign sel_srcB = grant_lsq ? lsq_srcB : iq_srcB;

    // Operand read; ascending loop lets the highest-numbered matching port win.
    always_comb begin
        rd_opA = rf_q[sel_srcA];
        rd_opB = rf_q[sel_srcB];
`ifdef REGREAD_WB_BYPASS_EN
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_en[k] && (wb_idx[k*PREG_W +: PREG_W] == sel_srcA)) begin
                rd_opA = wb_data[k*DATA_W +: DATA_W];
            end
            if (wb_en[k] && (wb_idx[k*PREG_W +: PREG_W] == sel_srcB)) begin
                rd_opB = wb_data[k*DATA_W +: DATA_W];
            end
        end
`endif
    end

    // Write-back is independent of FREEZE and the output handshake.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_WB; k++) begin
                if (wb_en[k]) begin
                    rf_q[wb_idx[k*PREG_W +: PREG_W]] <= wb_data[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        last_grant_d  = last_grant_q;
        out_valid_d   = out_valid_q;
        out_is_mem_d  = out_is_mem_q;
        out_rob_d     = out_rob_q;
        out_opA_d     = out_opA_q;
        out_opB_d     = out_opB_q;
        out_dest_d    = out_dest_q;
        out_payload_d = out_payload_q;
        if (advance) begin
            if (any_valid) begin
                last_grant_d  = grant_lsq;
                out_valid_d   = 1'b1;
                out_is_mem_d  = grant_lsq;
                out_rob_d     = grant_lsq ? lsq_rob     : iq_rob;
                out_dest_d    = grant_lsq ? lsq_dest    : iq_dest;
                out_payload_d = grant_lsq ? lsq_payload : iq_payload;
                out_opA_d     = rd_opA;
                out_opB_d     = rd_opB;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // last_grant resets to LSQ so the IQ wins the first tie.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            last_grant_q  <= 1'b1;
            out_valid_q   <= 1'b0;
            out_is_mem_q  <= 1'b0;
            out_rob_q     <= '0;
            out_opA_q     <= '0;
            out_opB_q     <= '0;
            out_dest_q    <= '0;
            out_payload_q <= '0;
        end else begin
            last_grant_q  <= last_grant_d;
            out_valid_q   <= out_valid_d;
            out_is_mem_q  <= out_is_mem_d;
            out_rob_q     <= out_rob_d;
            out_opA_q     <= out_opA_d;
            out_opB_q     <= out_opB_d;
            out_dest_q    <= out_dest_d;
            out_payload_q <= out_payload_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_is_mem  = out_is_mem_q;
    assign out_rob     = out_rob_q;
    assign out_opA     = out_opA_q;
    assign out_opB     = out_opB_q;
    assign out_dest    = out_dest_q;
    assign out_payload = out_payload_q;

endmodule

// File: tb/tb_regread_stage.sv
// Directed bench for regread_stage: arbitration order, stalls, freeze,
// write-back priority and (macro-dependent) forwarding.
module tb_regread_stage;

    localparam int DATA_W = 32;
    localparam int PREG_W = 6;
    localparam int ROB_W  = 6;
    localparam int PAY_W  = 64;
    localparam int NUM_WB = 2;

    logic                     CLK = 1'b0;
    logic                     RESET = 1'b0;
    logic                     FREEZE;
    logic                     iq_valid, lsq_valid;
    logic [ROB_W-1:0]         iq_rob, lsq_rob;
    logic [PREG_W-1:0]        iq_srcA, iq_srcB, iq_dest;
    logic [PREG_W-1:0]        lsq_srcA, lsq_srcB, lsq_dest;
    logic [PAY_W-1:0]         iq_payload, lsq_payload;
    logic                     iq_pop, lsq_pop;
    logic                     out_valid, out_ready, out_is_mem;
    logic [ROB_W-1:0]         out_rob;
    logic [DATA_W-1:0]        out_opA, out_opB;
    logic [PREG_W-1:0]        out_dest;
    logic [PAY_W-1:0]         out_payload;
    logic [NUM_WB-1:0]        wb_en;
    logic [NUM_WB*PREG_W-1:0] wb_idx;
    logic [NUM_WB*DATA_W-1:0] wb_data;

    int n_cmp = 0;
    int n_err = 0;

`ifdef REGREAD_WB_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    regread_stage #(
        .DATA_W(DATA_W), .PREG_W(PREG_W), .ROB_W(ROB_W), .PAY_W(PAY_W), .NUM_WB(NUM_WB)
    ) dut (
        .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE),
        .iq_valid(iq_valid), .iq_rob(iq_rob), .iq_srcA(iq_srcA), .iq_srcB(iq_srcB),
        .iq_dest(iq_dest), .iq_payload(iq_payload), .iq_pop(iq_pop),
        .lsq_valid(lsq_valid), .lsq_rob(lsq_rob), .lsq_srcA(lsq_srcA), .lsq_srcB(lsq_srcB),
        .lsq_dest(lsq_dest), .lsq_payload(lsq_payload), .lsq_pop(lsq_pop),
        .out_valid(out_valid), .out_ready(out_ready), .out_is_mem(out_is_mem),
        .out_rob(out_rob), .out_opA(out_opA), .out_opB(out_opB),
        .out_dest(out_dest), .out_payload(out_payload),
        .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data)
    );

    // Clock / reset
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        FREEZE = 1'b0; out_ready = 1'b1;
        iq_valid = 1'b0; iq_rob = '0; iq_srcA = '0; iq_srcB = '0; iq_dest = '0; iq_payload = '0;
        lsq_valid = 1'b0; lsq_rob = '0; lsq_srcA = '0; lsq_srcB = '0; lsq_dest = '0; lsq_payload = '0;
        wb_en = '0; wb_idx = '0; wb_data = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        RESET = 1'b0;
        step();
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        RESET = 1'b0;
        iq_valid = 1'b1; lsq_valid = 1'b1;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        n_cmp++; if (iq_pop !== 1'b0 || lsq_pop !== 1'b0) begin n_err++; $display("FAIL reset_pops got=%0b%0b exp=00", iq_pop, lsq_pop); end
        n_cmp++; if ({out_is_mem, out_rob, out_opA, out_opB, out_dest, out_payload} !== '0)
            begin n_err++; $display("FAIL reset_fields rob=%0h opA=%0h opB=%0h exp=0", out_rob, out_opA, out_opB); end
    endtask

    task automatic test_wb_read();
        do_reset();
        wb_en = 2'b01; wb_idx = {6'd0, 6'd5}; wb_data = {32'h0, 32'h0000_1234};
        step();
        wb_en = '0;
        iq_valid = 1'b1; iq_srcA = 6'd5; iq_srcB = 6'd0; iq_rob = 6'd1; iq_dest = 6'd7;
        iq_payload = 64'hDEAD_0000_0000_0001;
        #1;
        n_cmp++; if (iq_pop !== 1'b1 || lsq_pop !== 1'b0) begin n_err++; $display("FAIL wbread_pop got=%0b%0b exp=10", iq_pop, lsq_pop); end
        step();
        iq_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL wbread_valid got=%0b exp=1", out_valid); end
        n_cmp++; if (out_opA !== 32'h1234) begin n_err++; $display("FAIL wbread_opA got=%0h exp=1234", out_opA); end
        n_cmp++; if (out_opB !== 32'h0) begin n_err++; $display("FAIL wbread_opB got=%0h exp=0", out_opB); end
        n_cmp++; if (out_is_mem !== 1'b0) begin n_err++; $display("FAIL wbread_is_mem got=%0b exp=0", out_is_mem); end
        n_cmp++; if (out_rob !== 6'd1 || out_dest !== 6'd7) begin n_err++; $display("FAIL wbread_rob_dest got=%0d/%0d exp=1/7", out_rob, out_dest); end
        n_cmp++; if (out_payload !== 64'hDEAD_0000_0000_0001) begin n_err++; $display("FAIL wbread_payload got=%0h", out_payload); end
        #1;
        n_cmp++; if (iq_pop !== 1'b0 || lsq_pop !== 1'b0) begin n_err++; $display("FAIL wbread_idle_pop got=%0b%0b exp=00", iq_pop, lsq_pop); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL wbread_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_alternate();
        do_reset();
        iq_valid = 1'b1; iq_rob = 6'd10; iq_payload = 64'h1;
        lsq_valid = 1'b1; lsq_rob = 6'd20; lsq_payload = 64'h2;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (iq_pop !== ~i[0] || lsq_pop !== i[0])
                begin n_err++; $display("FAIL alt_pop%0d got=%0b%0b exp=%0b%0b", i, iq_pop, lsq_pop, ~i[0], i[0]); end
            step();
            n_cmp++; if (out_is_mem !== i[0] || out_rob !== (i[0] ? 6'd20 : 6'd10))
                begin n_err++; $display("FAIL alt_out%0d got=%0b/%0d exp=%0b", i, out_is_mem, out_rob, i[0]); end
        end
    endtask

    task automatic test_back_to_back_stall();
        do_reset();
        iq_valid = 1'b1; iq_rob = 6'd3; lsq_valid = 1'b1; lsq_rob = 6'd4; out_ready = 1'b0;
        step();
        iq_rob = 6'd33;
        n_cmp++; if (out_valid !== 1'b1 || out_rob !== 6'd3) begin n_err++; $display("FAIL stall_load got=%0b/%0d exp=1/3", out_valid, out_rob); end
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (iq_pop !== 1'b0 || lsq_pop !== 1'b0) begin n_err++; $display("FAIL stall_pop%0d got=%0b%0b exp=00", i, iq_pop, lsq_pop); end
            step();
            n_cmp++; if (out_valid !== 1'b1 || out_rob !== 6'd3 || out_is_mem !== 1'b0)
                begin n_err++; $display("FAIL stall_hold%0d got=%0b/%0d exp=1/3", i, out_valid, out_rob); end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (lsq_pop !== 1'b1 || iq_pop !== 1'b0) begin n_err++; $display("FAIL stall_release got=%0b%0b exp=01", iq_pop, lsq_pop); end
        step();
        n_cmp++; if (out_is_mem !== 1'b1 || out_rob !== 6'd4) begin n_err++; $display("FAIL stall_next got=%0b/%0d exp=1/4", out_is_mem, out_rob); end
        // Reset during a stall must drop the held instruction immediately.
        out_ready = 1'b0;
        #2;
        RESET = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_rob !== '0) begin n_err++; $display("FAIL stall_reset got=%0b/%0d exp=0/0", out_valid, out_rob); end
        RESET = 1'b1;
    endtask

    task automatic test_bypass();
        do_reset();
        lsq_valid = 1'b1; lsq_srcA = 6'd0; lsq_srcB = 6'd9; lsq_rob = 6'd5;
        wb_en = 2'b10; wb_idx = {6'd9, 6'd0}; wb_data = {32'h0000_BEEF, 32'h0};
        #1;
        n_cmp++; if (lsq_pop !== 1'b1) begin n_err++; $display("FAIL byp_pop got=%0b exp=1", lsq_pop); end
        step();
        wb_en = '0;
        n_cmp++; if (out_opB !== (BYPASS ? 32'hBEEF : 32'h0))
            begin n_err++; $display("FAIL byp_opB got=%0h exp=%0h", out_opB, BYPASS ? 32'hBEEF : 32'h0); end
        step();
        n_cmp++; if (out_opB !== 32'hBEEF || out_is_mem !== 1'b1) begin n_err++; $display("FAIL byp_after got=%0h exp=beef", out_opB); end
    endtask

    task automatic test_wb_priority();
        do_reset();
        wb_en = 2'b11; wb_idx = {6'd3, 6'd3}; wb_data = {32'h22, 32'h11};
        iq_valid = 1'b1; iq_srcA = 6'd3; iq_srcB = 6'd1;
        step();
        wb_en = '0; iq_srcB = 6'd3;
        n_cmp++; if (out_opA !== (BYPASS ? 32'h22 : 32'h0))
            begin n_err++; $display("FAIL prio_fwd got=%0h exp=%0h", out_opA, BYPASS ? 32'h22 : 32'h0); end
        step();
        iq_valid = 1'b0;
        n_cmp++; if (out_opA !== 32'h22 || out_opB !== 32'h22)
            begin n_err++; $display("FAIL prio_write got=%0h/%0h exp=22/22", out_opA, out_opB); end
    endtask

    task automatic test_freeze();
        do_reset();
        iq_valid = 1'b1; iq_rob = 6'd1;
        step();
        FREEZE = 1'b1; iq_rob = 6'd2; lsq_valid = 1'b1; lsq_rob = 6'd8; lsq_srcA = 6'd12;
        wb_en = 2'b01; wb_idx = {6'd0, 6'd12}; wb_data = {32'h0, 32'h0000_CAFE};
        #1;
        n_cmp++; if (iq_pop !== 1'b0 || lsq_pop !== 1'b0) begin n_err++; $display("FAIL frz_pop got=%0b%0b exp=00", iq_pop, lsq_pop); end
        step();
        wb_en = '0;
        n_cmp++; if (out_valid !== 1'b1 || out_rob !== 6'd1) begin n_err++; $display("FAIL frz_hold got=%0b/%0d exp=1/1", out_valid, out_rob); end
        step();
        n_cmp++; if (out_rob !== 6'd1) begin n_err++; $display("FAIL frz_hold2 got=%0d exp=1", out_rob); end
        FREEZE = 1'b0;
        #1;
        n_cmp++; if (lsq_pop !== 1'b1) begin n_err++; $display("FAIL frz_release got=%0b exp=1", lsq_pop); end
        step();
        n_cmp++; if (out_opA !== 32'hCAFE || out_rob !== 6'd8) begin n_err++; $display("FAIL frz_write got=%0h/%0d exp=cafe/8", out_opA, out_rob); end
    endtask

    initial begin
        test_reset();
        test_wb_read();
        test_alternate();
        test_back_to_back_stall();
        test_bypass();
        test_wb_priority();
        test_freeze();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
